// File: rtl/dense_skew_feeder_if.sv
// dense_skew_feeder_if: bus bundle between the dense-buffer skew feeder and its environment.
// Compile-time option: DENSE_FEED_PERF_CNT_EN adds perf_cyc_o / perf_stall_o.
// Ports (feeder view, modport master):
//   in : start_i, base_addr_i, row_cnt_i, stall_i, rd_data_i
//   out: rd_en_o, rd_addr_o, arr_valid_o, arr_data_o, busy_o, done_o [, perf_cyc_o, perf_stall_o]
// Modport slave is the environment side (buffer, array, controller).
interface dense_skew_feeder_if #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = LANES * 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [6:0]            row_cnt_i;
    logic                  stall_i;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic [LANES-1:0]      arr_valid_o;
    logic [DATA_WIDTH-1:0] arr_data_o;
    logic                  busy_o;
    logic                  done_o;
`ifdef DENSE_FEED_PERF_CNT_EN
    logic [15:0]           perf_cyc_o;
    logic [15:0]           perf_stall_o;
`endif
    modport master (
        input  start_i, base_addr_i, row_cnt_i, stall_i, rd_data_i,
        output rd_en_o, rd_addr_o, arr_valid_o, arr_data_o, busy_o, done_o
`ifdef DENSE_FEED_PERF_CNT_EN
        , output perf_cyc_o, perf_stall_o
`endif
    );
    modport slave (
        output start_i, base_addr_i, row_cnt_i, stall_i, rd_data_i,
        input  rd_en_o, rd_addr_o, arr_valid_o, arr_data_o, busy_o, done_o
`ifdef DENSE_FEED_PERF_CNT_EN
        , input perf_cyc_o, perf_stall_o
`endif
    );
endinterface

// File: rtl/dense_skew_feeder.sv
// dense_skew_feeder: streams rows from the dense operand buffer into the array with per-lane skew.
// Compile-time option: DENSE_FEED_PERF_CNT_EN adds busy/stall cycle counters.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - dense_skew_feeder_if.master: start/base/count request, stall, buffer read port,
//          skewed array outputs (lane k delayed k cycles), busy and done pulse
module dense_skew_feeder #(
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 60
) (
    input  logic                clk,
    input  logic                rstn,
    dense_skew_feeder_if.master bus
);
    localparam int DW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [6:0]            rows_q, rows_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  active;
    logic                  shift;

    assign active = (state_q == READ) || (state_q == DRAIN);
    // The whole skew pipe advances only on non-stalled active cycles.
    assign shift  = active && !bus.stall_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rows_d  = rows_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                rows_d  = (bus.row_cnt_i > 7'(DEPTH)) ? 7'(DEPTH) : bus.row_cnt_i;
                addr_d  = bus.base_addr_i;
                state_d = (bus.row_cnt_i == 7'd0) ? DONE : READ;
            end
            READ: if (!bus.stall_i) begin
                addr_d  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                rows_d  = rows_q - 1'b1;
                drain_d = '0;
                state_d = (rows_q == 7'd1) ? DRAIN : READ;
            end
            DRAIN: if (!bus.stall_i) begin
                drain_d = drain_q + 1'b1;
                state_d = (drain_q == DW'(LANES - 1)) ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            drain_q <= drain_d;
        end
    end

    assign bus.rd_en_o   = (state_q == READ) && !bus.stall_i;
    assign bus.rd_addr_o = (state_q == READ) ? addr_q : '0;
    assign bus.busy_o    = active;
    assign bus.done_o    = (state_q == DONE);

    // Lane k is a (k+1)-deep chain of {valid, byte}; stage 0 loads the read row in READ
    // and zeros in DRAIN, so the last stage shows the row k+1 shifts after it was read.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [k:0][8:0] sh_q, sh_d;
        always_comb begin
            sh_d = sh_q;
            if (shift) begin
                sh_d[0] = (state_q == READ) ? {1'b1, bus.rd_data_i[8*k +: 8]} : 9'd0;
                for (int j = 1; j <= k; j++) sh_d[j] = sh_q[j-1];
            end
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sh_q <= '0;
            else       sh_q <= sh_d;
        end
        assign bus.arr_valid_o[k]       = sh_q[k][8];
        assign bus.arr_data_o[8*k +: 8] = sh_q[k][8] ? sh_q[k][7:0] : 8'd0;
    end

`ifdef DENSE_FEED_PERF_CNT_EN
    logic [15:0] pcyc_q, pcyc_d, pstall_q, pstall_d;

    // Counters restart on an accepted start and hold after the run until the next one.
    always_comb begin
        pcyc_d   = pcyc_q;
        pstall_d = pstall_q;
        if (state_q == IDLE && bus.start_i) begin
            pcyc_d   = '0;
            pstall_d = '0;
        end else if (active) begin
            pcyc_d   = (&pcyc_q) ? pcyc_q : pcyc_q + 1'b1;
            pstall_d = (bus.stall_i && !(&pstall_q)) ? pstall_q + 1'b1 : pstall_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else begin
            pcyc_q   <= pcyc_d;
            pstall_q <= pstall_d;
        end
    end

    assign bus.perf_cyc_o   = pcyc_q;
    assign bus.perf_stall_o = pstall_q;
`endif
endmodule
